// File: rtl/vic_pkg.sv
// vic_pkg: register offsets, border edge values and the C64 palette
// shared by the VIC border/raster stage.
package vic_pkg;

  localparam logic [5:0] REG_CR1    = 6'h11;
  localparam logic [5:0] REG_RASTER = 6'h12;
  localparam logic [5:0] REG_LPX    = 6'h13;
  localparam logic [5:0] REG_LPY    = 6'h14;
  localparam logic [5:0] REG_CR2    = 6'h16;
  localparam logic [5:0] REG_IRQ    = 6'h19;
  localparam logic [5:0] REG_IRQEN  = 6'h1A;
  localparam logic [5:0] REG_BORDER = 6'h20;
  localparam logic [5:0] REG_BG0    = 6'h21;

  localparam logic [9:0] LEFT_CSEL1  = 10'd24;
  localparam logic [9:0] LEFT_CSEL0  = 10'd31;
  localparam logic [9:0] RIGHT_CSEL1 = 10'd344;
  localparam logic [9:0] RIGHT_CSEL0 = 10'd335;
  localparam logic [9:0] TOP_RSEL1   = 10'd51;
  localparam logic [9:0] TOP_RSEL0   = 10'd55;
  localparam logic [9:0] BOT_RSEL1   = 10'd251;
  localparam logic [9:0] BOT_RSEL0   = 10'd247;

  localparam logic [7:0] CR1_RST = 8'h1B;
  localparam logic [5:0] CR2_RST = 6'h08;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t PALETTE [16] = '{
    12'h000, 12'hFFF, 12'h632, 12'h7AB,
    12'h638, 12'h584, 12'h327, 12'hBC6,
    12'h642, 12'h430, 12'h965, 12'h444,
    12'h666, 12'h9D8, 12'h65B, 12'h999
  };

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
    logic [9:0] top;
    logic [9:0] bottom;
  } edges_t;

  function automatic edges_t border_edges(
    input logic csel,
    input logic rsel
  );
    edges_t e;
    e.left   = csel ? LEFT_CSEL1  : LEFT_CSEL0;
    e.right  = csel ? RIGHT_CSEL1 : RIGHT_CSEL0;
    e.top    = rsel ? TOP_RSEL1   : TOP_RSEL0;
    e.bottom = rsel ? BOT_RSEL1   : BOT_RSEL0;
    return e;
  endfunction

endpackage

// File: rtl/vic_palette_rom.sv
// vic_palette_rom: registered colour index to 12-bit RGB lookup,
// blanked outside the visible area.
module vic_palette_rom
  import vic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_idx,
  input  logic       i_en,
  output rgb12_t     o_rgb
);

  rgb12_t rgb_q;
  rgb12_t rgb_d;

  always_comb begin
    rgb_d = '0;
    if (i_en) rgb_d = PALETTE[i_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign o_rgb = rgb_q;

endmodule

// File: rtl/vic_border_raster.sv
// vic_border_raster: border flip-flops, raster IRQ, CPU registers and
// palette output. Light-pen capture is built when VIC_LIGHTPEN_IRQ_EN is defined.
module vic_border_raster
  import vic_pkg::*;
#(
  parameter logic [9:0] H_ORIGIN        = 10'd0,
  parameter logic [9:0] V_ORIGIN        = 10'd0,
  parameter int         LINES_PER_FRAME = 312
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_display_on,
  input  logic       i_reg_we,
  input  logic [5:0] i_reg_addr,
  input  logic [7:0] i_reg_wdata,
`ifdef VIC_LIGHTPEN_IRQ_EN
  input  logic       i_lp_n,
`endif
  output logic [7:0] o_reg_rdata,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_irq_n
);

  localparam logic [9:0] LPF = 10'(LINES_PER_FRAME);

  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] raster;
  edges_t     edg;

  logic [7:0] cr1_q, cr1_d;
  logic [7:0] rlo_q, rlo_d;
  logic [5:0] cr2_q, cr2_d;
  logic [3:0] en_q, en_d;
  logic [3:0] bc_q, bc_d;
  logic [3:0] bg_q, bg_d;
  logic [3:0] flags_q, flags_d;
  logic       main_q, main_d;
  logic       vert_q, vert_d;
  logic       irq_n_q;
  logic [3:0] idx_q;
  logic       de_q;

  logic [8:0] rc;
  logic       irq_any;
  logic       den;
  logic       lp_hit;
  logic [7:0] lpx;
  logic [7:0] lpy;
  rgb12_t     rgb;

  assign x      = i_hpos - H_ORIGIN;
  assign y      = i_vpos - V_ORIGIN;
  assign raster = (y >= LPF) ? y - LPF : y;
  assign edg    = border_edges(cr2_q[3], cr1_q[3]);
  assign den    = cr1_q[4];
  assign rc     = {cr1_q[7], rlo_q};
  assign irq_any = |(flags_q & en_q);

  // Vertical checks run at x == 0 and again at x == left; main_ff
  // clears at left only once the vertical flop is open.
  always_comb begin
    main_d = main_q;
    vert_d = vert_q;
    if (x == edg.right) main_d = 1'b1;
    if (x == 10'd0 || x == edg.left) begin
      if (raster == edg.bottom)
        vert_d = 1'b1;
      else if (raster == edg.top && den)
        vert_d = 1'b0;
    end
    if (x == edg.left && !vert_d) main_d = 1'b0;
  end

  always_comb begin
    cr1_d   = cr1_q;
    rlo_d   = rlo_q;
    cr2_d   = cr2_q;
    en_d    = en_q;
    bc_d    = bc_q;
    bg_d    = bg_q;
    flags_d = flags_q;
    if (i_reg_we) begin
      case (i_reg_addr)
        REG_CR1:    cr1_d   = i_reg_wdata;
        REG_RASTER: rlo_d   = i_reg_wdata;
        REG_CR2:    cr2_d   = i_reg_wdata[5:0];
        REG_IRQ:    flags_d = flags_q & ~i_reg_wdata[3:0];
        REG_IRQEN:  en_d    = i_reg_wdata[3:0];
        REG_BORDER: bc_d    = i_reg_wdata[3:0];
        REG_BG0:    bg_d    = i_reg_wdata[3:0];
        default:    ;
      endcase
    end
    // Set events come after the clear so they win a collision.
    if (x == 10'd0 && raster == {1'b0, rc}) flags_d[0] = 1'b1;
    if (lp_hit) flags_d[3] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cr1_q   <= CR1_RST;
      rlo_q   <= '0;
      cr2_q   <= CR2_RST;
      en_q    <= '0;
      bc_q    <= '0;
      bg_q    <= '0;
      flags_q <= '0;
      main_q  <= 1'b1;
      vert_q  <= 1'b1;
      irq_n_q <= 1'b1;
      idx_q   <= '0;
      de_q    <= 1'b0;
    end else begin
      cr1_q   <= cr1_d;
      rlo_q   <= rlo_d;
      cr2_q   <= cr2_d;
      en_q    <= en_d;
      bc_q    <= bc_d;
      bg_q    <= bg_d;
      flags_q <= flags_d;
      main_q  <= main_d;
      vert_q  <= vert_d;
      irq_n_q <= ~irq_any;
      idx_q   <= main_d ? bc_q : bg_q;
      de_q    <= i_display_on;
    end
  end

`ifdef VIC_LIGHTPEN_IRQ_EN
  logic       lp_q;
  logic       armed_q, armed_d;
  logic [7:0] lpx_q, lpx_d;
  logic [7:0] lpy_q, lpy_d;

  always_comb begin
    armed_d = armed_q;
    lpx_d   = lpx_q;
    lpy_d   = lpy_q;
    lp_hit  = 1'b0;
    if (x == 10'd0 && raster == 10'd0) armed_d = 1'b1;
    if (lp_q && !i_lp_n && armed_q) begin
      lp_hit  = 1'b1;
      armed_d = 1'b0;
      lpx_d   = x[8:1];
      lpy_d   = raster[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lp_q    <= 1'b1;
      armed_q <= 1'b1;
      lpx_q   <= '0;
      lpy_q   <= '0;
    end else begin
      lp_q    <= i_lp_n;
      armed_q <= armed_d;
      lpx_q   <= lpx_d;
      lpy_q   <= lpy_d;
    end
  end

  assign lpx = lpx_q;
  assign lpy = lpy_q;
`else
  assign lp_hit = 1'b0;
  assign lpx    = '0;
  assign lpy    = '0;
`endif

  always_comb begin
    o_reg_rdata = 8'hFF;
    case (i_reg_addr)
      REG_CR1:    o_reg_rdata = {raster[8], cr1_q[6:0]};
      REG_RASTER: o_reg_rdata = raster[7:0];
      REG_LPX:    o_reg_rdata = lpx;
      REG_LPY:    o_reg_rdata = lpy;
      REG_CR2:    o_reg_rdata = {2'b11, cr2_q};
      REG_IRQ:    o_reg_rdata = {irq_any, 3'b111, flags_q};
      REG_IRQEN:  o_reg_rdata = {4'hF, en_q};
      REG_BORDER: o_reg_rdata = {4'hF, bc_q};
      REG_BG0:    o_reg_rdata = {4'hF, bg_q};
      default:    ;
    endcase
  end

  vic_palette_rom u_pal (
    .clk   (clk),
    .reset (reset),
    .i_idx (idx_q),
    .i_en  (de_q),
    .o_rgb (rgb)
  );

  assign o_red   = rgb[11:8];
  assign o_green = rgb[7:4];
  assign o_blue  = rgb[3:0];
  assign o_irq_n = irq_n_q;

endmodule

// File: tb/tb_vic_border_raster.sv
// tb_vic_border_raster: randomized frames against a geometric border
// model plus directed raster-IRQ and reset steps.
module tb_vic_border_raster;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       de, we;
  logic [5:0] addr;
  logic [7:0] wd;
  logic [7:0] rdata;
  logic [3:0] red, green, blue;
  logic       irq_n;
`ifdef VIC_LIGHTPEN_IRQ_EN
  logic       lp_n = 1'b1;
`endif

  always #5 clk = ~clk;

  vic_border_raster dut (
    .clk          (clk),
    .reset        (reset),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .i_display_on (de),
    .i_reg_we     (we),
    .i_reg_addr   (addr),
    .i_reg_wdata  (wd),
`ifdef VIC_LIGHTPEN_IRQ_EN
    .i_lp_n       (lp_n),
`endif
    .o_reg_rdata  (rdata),
    .o_red        (red),
    .o_green      (green),
    .o_blue       (blue),
    .o_irq_n      (irq_n)
  );

  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'hFFF, 12'h632, 12'h7AB,
    12'h638, 12'h584, 12'h327, 12'hBC6,
    12'h642, 12'h430, 12'h965, 12'h444,
    12'h666, 12'h9D8, 12'h65B, 12'h999
  };

  int n_chk = 0;
  int n_pass = 0;
  int cur_v = 0;

  int m_cr1, m_rlo, m_cr2, m_en, m_bc, m_bg, m_flags;
  bit m_irqn;
  logic [11:0] p1, out_exp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int rast(input int v);
    return (v >= 312) ? v - 312 : v;
  endfunction

  // Inside the display window the background shows; else the border.
  function automatic bit is_border(input int x, input int r);
    int left, right, top, bot;
    bit den;
    left  = m_cr2[3] ? 24 : 31;
    right = m_cr2[3] ? 344 : 335;
    top   = m_cr1[3] ? 51 : 55;
    bot   = m_cr1[3] ? 251 : 247;
    den   = m_cr1[4];
    return !(den && r >= top && r < bot && x >= left && x < right);
  endfunction

  function automatic logic [7:0] mread(input int a);
    int r;
    r = rast(int'(vpos));
    case (a)
      'h11: return 8'(((r >> 8) & 1) << 7 | (m_cr1 & 'h7F));
      'h12: return 8'(r & 'hFF);
      'h13, 'h14: return 8'h00;
      'h16: return 8'('hC0 | m_cr2);
      'h19: return 8'(((m_flags & m_en) != 0 ? 'h80 : 0) | 'h70 | m_flags);
      'h1A: return 8'('hF0 | m_en);
      'h20: return 8'('hF0 | m_bc);
      'h21: return 8'('hF0 | m_bg);
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick(input int x, input int v, input bit d, input bit w,
                      input int a, input int wdv, input bit rst);
    int r, nf, rc;
    hpos = 10'(x); vpos = 10'(v); de = d; we = w;
    addr = 6'(a); wd = 8'(wdv); reset = rst;
    @(posedge clk);
    if (rst) begin
      m_cr1 = 'h1B; m_rlo = 0; m_cr2 = 'h08; m_en = 0;
      m_bc = 0; m_bg = 0; m_flags = 0; m_irqn = 1'b1;
      out_exp = '0; p1 = '0;
    end else begin
      r = rast(v);
      rc = ((m_cr1 >> 7) << 8) | m_rlo;
      m_irqn = ((m_flags & m_en) == 0);
      out_exp = p1;
      p1 = d ? PAL[is_border(x, r) ? m_bc : m_bg] : 12'h000;
      nf = m_flags;
      if (w && a == 'h19) nf = nf & ~wdv & 'hF;
      if (x == 0 && r == rc) nf = nf | 1;
      if (w) begin
        case (a)
          'h11: m_cr1 = wdv & 'hFF;
          'h12: m_rlo = wdv & 'hFF;
          'h16: m_cr2 = wdv & 'h3F;
          'h1A: m_en  = wdv & 'hF;
          'h20: m_bc  = wdv & 'hF;
          'h21: m_bg  = wdv & 'hF;
          default: ;
        endcase
      end
      m_flags = nf;
    end
    #1;
    we = 1'b0;
    chk($sformatf("rgb x%0d v%0d", x, v), {red, green, blue}, out_exp);
    chk($sformatf("irq_n x%0d v%0d", x, v), irq_n, m_irqn);
  endtask

  task automatic wr(input int a, input int v);
    tick(370, cur_v, 1'b0, 1'b1, a, v, 1'b0);
  endtask

  task automatic idle();
    tick(370, cur_v, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic rd_check(input int a, input string tag);
    addr = 6'(a);
    #1;
    chk(tag, rdata, mread(a));
  endtask

  task automatic rd_const(input int a, input logic [7:0] exp,
                          input string tag);
    addr = 6'(a);
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic run_line(input int r);
    for (int x = 0; x < 360; x++)
      tick(x, r, ($urandom_range(7, 0) != 0), 1'b0, 0, 0, 1'b0);
    cur_v = r;
  endtask

  task automatic run_frame(input bit csel, input bit rsel, input bit den,
                           input int bc, input int bg,
                           input int mid, input int late);
    int top, bot;
    int ln [7];
    wr('h11, (m_cr1 & 'h80) | (int'(den) << 4) | (int'(rsel) << 3) | 3);
    wr('h16, 'hC0 | (int'(csel) << 3));
    wr('h20, bc);
    wr('h21, bg);
    top = rsel ? 51 : 55;
    bot = rsel ? 251 : 247;
    ln[0] = $urandom_range(top - 2, 0);
    ln[1] = top - 1;
    ln[2] = top;
    ln[3] = (mid >= 0) ? mid : $urandom_range(bot - 2, top + 1);
    ln[4] = bot - 1;
    ln[5] = bot;
    ln[6] = (late >= 0) ? late : $urandom_range(311, bot + 1);
    for (int i = 0; i < 7; i++) run_line(ln[i]);
  endtask

  int rc;

  initial begin
    tick(370, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    tick(370, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    rd_const('h11, 8'h1B, "rst d011");
    rd_const('h16, 8'hC8, "rst d016");
    rd_const('h19, 8'h70, "rst d019");
    rd_const('h20, 8'hF0, "rst d020");
    rd_const('h3F, 8'hFF, "unmapped");
`ifndef VIC_LIGHTPEN_IRQ_EN
    rd_const('h13, 8'h00, "d013");
    rd_const('h14, 8'h00, "d014");
`endif

    run_frame(1'b1, 1'b1, 1'b1, 2, 6, 100, -1);
    run_frame(1'b1, 1'b1, 1'b0, 2, 6, 100, -1);
    run_frame(1'b0, 1'b0, 1'b1, 2, 6, -1, -1);
    run_frame(1'b0, 1'b1, 1'b1, 5, 9, -1, -1);
    run_frame(1'b1, 1'b0, 1'b1, 14, 1, -1, -1);

    wr('h1A, 1);
    wr('h12, 5);
    wr('h11, 'h9B);
    wr('h19, 'hF);
    run_frame(1'b1, 1'b1, 1'b1, 2, 6, 100, 261);
    rd_const('h19, 8'hF1, "d019 hit");
    chk("irq asserted", irq_n, 1'b0);
    wr('h19, 1);
    idle();
    chk("irq released", irq_n, 1'b1);

    tick(0, 261, 1'b0, 1'b1, 'h19, 1, 1'b0);
    cur_v = 261;
    rd_const('h19, 8'hF1, "set beats clear");
    idle();
    chk("irq after collide", irq_n, 1'b0);
    wr('h19, 1);
    tick(100, 262, 1'b0, 1'b1, 'h12, 6, 1'b0);
    cur_v = 262;
    idle();
    rd_const('h19, 8'h70, "midline rc write");
    tick(370, 317, 1'b0, 1'b0, 0, 0, 1'b0);
    cur_v = 317;
    rd_const('h12, 8'h05, "raster wrap");
    rd_check('h11, "d011 wrap");

    wr('h11, 'h1B);
    wr('h12, 40);
    wr('h1A, 1);
    run_line(40);
    run_line(51);
    for (int x = 0; x <= 200; x++)
      tick(x, 150, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("irq pending", irq_n, 1'b0);
    tick(201, 150, 1'b1, 1'b0, 0, 0, 1'b1);
    cur_v = 150;
    chk("rst irq_n", irq_n, 1'b1);
    chk("rst rgb", {red, green, blue}, 12'h000);
    rd_const('h11, 8'h1B, "rst d011 l150");
    tick(370, 300, 1'b0, 1'b0, 0, 0, 1'b0);
    cur_v = 300;
    rd_const('h11, 8'h9B, "d011 bit8");

    for (int f = 0; f < 6; f++) begin
      rc = $urandom_range(311, 0);
      wr('h12, rc & 'hFF);
      wr('h11, ((rc >> 8) << 7) | (m_cr1 & 'h7F));
      wr('h1A, $urandom_range(15, 0));
      wr('h19, 'hF);
      run_frame($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                $urandom_range(3, 0) != 0, $urandom_range(15, 0),
                $urandom_range(15, 0), -1, -1);
      rd_check('h19, "d019 rnd");
      rd_check('h12, "d012 rnd");
      rd_check('h11, "d011 rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
